// File: rtl/instruction_control.sv
// instruction_control
// Sits behind the phase Sequencer. It latches the fetched instruction and tells the
// Sequencer which address phases to run (SEQTYPE) and when execution ends (DONE).
// It also checks that strobes arrive in a legal order and counts retired instructions.
// The strobe-order checker is a small FSM that tracks the index of the next STB bit
// it expects (r_exp). Any deviation raises a sticky SEQERR and drops the FSM back to
// IDLE. A further STB[0] then resynchronises the FSM to the instruction stream.

module instruction_control #(
  parameter int CNT_W = 16
) (
  input  logic             SYSCLK,
  input  logic             RESET,
  input  logic [9:0]       CK,
  input  logic [9:0]       STB,
  input  logic [11:0]      MEMDATA,
  output logic [1:0]       SEQTYPE,
  output logic             DONE,
  output logic [11:0]      IR,
  output logic [7:0]       OPCODE,
  output logic [3:0]       CURPHASE,
  output logic [CNT_W-1:0] INSTCNT,
  output logic             SEQERR
);

  // Strobe indices of the fixed phases within CK/STB.
  localparam logic [3:0] IDX_FETCH = 4'd0;
  localparam logic [3:0] IDX_AUTO1 = 4'd1;
  localparam logic [3:0] IDX_IND   = 4'd3;
  localparam logic [3:0] IDX_EXEC1 = 4'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_EXEC = 2'd2
  } state_t;

  // ------------------------------------------------------------------
  // Decode helpers
  // ------------------------------------------------------------------

  // Returns {isPPIND, isIND} for instruction bits [11:3].
  // Page-0 autoindex locations 0010-0017 (octal) have bit 7 clear and bits 6:3 equal
  // to 0001. An indirect reference through one of them needs the AUTO1/AUTO2 phases.
  function automatic logic [1:0] f_decode(input logic [8:0] x_hi);
    logic memref;
    logic ind;
    logic ppind;
    memref = (x_hi[8:6] < 3'd6);
    ind    = memref & x_hi[5];
    ppind  = ind & ~x_hi[4] & (x_hi[3:0] == 4'b0001);
    return {ppind, ind};
  endfunction

  // Number of execute phases for each major opcode.
  function automatic logic [1:0] f_exec_n(input logic [2:0] op);
    logic [1:0] n;
    case (op)
      3'd0:    n = 2'd2;  // AND
      3'd1:    n = 2'd2;  // TAD
      3'd2:    n = 2'd3;  // ISZ
      3'd3:    n = 2'd2;  // DCA
      3'd4:    n = 2'd2;  // JMS
      3'd5:    n = 2'd1;  // JMP
      3'd6:    n = 2'd3;  // IOT
      default: n = 2'd2;  // OPR
    endcase
    return n;
  endfunction

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  state_t             r_state;
  logic [3:0]         r_exp;
  logic [11:0]        r_ir;
  logic [CNT_W-1:0]   r_instcnt;
  logic               r_seqerr;

  // ------------------------------------------------------------------
  // Combinational nets
  // ------------------------------------------------------------------
  state_t             w_state_next;
  logic [3:0]         w_exp_next;
  logic               w_retire;

  logic [1:0]         w_dec_mem;
  logic [1:0]         w_dec_ir;
  logic [3:0]         w_done_idx;
  logic               w_done;
  logic [9:0]         w_exp_onehot;
  logic               w_stb_any;
  logic               w_stb_multi;
  logic               w_ck_multi;
  logic               w_stb_hit;
  logic               w_err;
  logic [3:0]         w_fetch_exp;
  logic [3:0]         w_curphase;

  assign w_dec_mem = f_decode(MEMDATA[11:3]);
  assign w_dec_ir  = f_decode(r_ir[11:3]);

  // The last execute strobe is STB[3+N]. Execute phase 1 is STB[4].
  assign w_done_idx = 4'd3 + {2'b00, f_exec_n(r_ir[11:9])};

  // The strobe check compares against a one-hot of r_exp. IDLE keeps r_exp at 0, so
  // the only strobe allowed in IDLE is the fetch strobe.
  assign w_exp_onehot = 10'b00_0000_0001 << r_exp;
  assign w_stb_any    = |STB;
  assign w_stb_multi  = |(STB & (STB - 10'd1));
  assign w_ck_multi   = |(CK & (CK - 10'd1));
  assign w_stb_hit    = |(STB & w_exp_onehot);
  assign w_err        = w_ck_multi | w_stb_multi | (w_stb_any & (STB != w_exp_onehot));

  // A fetch jumps to the first address phase it needs, or straight to execute.
  assign w_fetch_exp = w_dec_mem[1] ? IDX_AUTO1 :
                       w_dec_mem[0] ? IDX_IND   : IDX_EXEC1;

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------

  // Advance the strobe tracker. Reset wins over everything.
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_exp   <= IDX_FETCH;
    end else begin
      r_state <= w_state_next;
      r_exp   <= w_exp_next;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------

  // Choose the next state and expected strobe. Any protocol error aborts to IDLE,
  // even when the same cycle also carries a legal fetch strobe.
  always_comb begin
    w_state_next = r_state;
    w_exp_next   = r_exp;
    w_retire     = 1'b0;
    if (w_err) begin
      w_state_next = S_IDLE;
      w_exp_next   = IDX_FETCH;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (STB[IDX_FETCH]) begin
            w_exp_next   = w_fetch_exp;
            w_state_next = (w_fetch_exp < IDX_EXEC1) ? S_ADDR : S_EXEC;
          end
        end
        S_ADDR: begin
          if (w_stb_hit) begin
            if (r_exp == IDX_IND) begin
              w_state_next = S_EXEC;
              w_exp_next   = IDX_EXEC1;
            end else begin
              w_exp_next   = r_exp + 4'd1;
            end
          end
        end
        S_EXEC: begin
          if (w_stb_hit) begin
            if (w_done) begin
              w_state_next = S_IDLE;
              w_exp_next   = IDX_FETCH;
              w_retire     = 1'b1;
            end else begin
              w_exp_next   = r_exp + 4'd1;
            end
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_exp_next   = IDX_FETCH;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // FSM: outputs to the Sequencer
  // ------------------------------------------------------------------

  // SEQTYPE goes back to the Sequencer with no delay, so it must reflect the word on
  // the bus during the fetch strobe. DONE is the last execute strobe of this opcode.
  always_comb begin
    SEQTYPE = 2'b00;
    w_done  = 1'b0;
    if (!RESET) begin
      SEQTYPE = STB[IDX_FETCH] ? w_dec_mem : w_dec_ir;
      w_done  = (r_state == S_EXEC) & STB[w_done_idx];
    end
  end

  assign DONE = w_done;

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------

  // Load the instruction register on every fetch strobe.
  // The error flag is sticky until reset. The retire counter wraps naturally.
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      r_ir      <= 12'd0;
      r_instcnt <= '0;
      r_seqerr  <= 1'b0;
    end else begin
      if (STB[IDX_FETCH]) begin
        r_ir <= MEMDATA;
      end
      if (w_retire) begin
        r_instcnt <= r_instcnt + 1'b1;
      end
      if (w_err) begin
        r_seqerr <= 1'b1;
      end
    end
  end

  assign IR      = r_ir;
  assign INSTCNT = r_instcnt;
  assign SEQERR  = r_seqerr;

  // ------------------------------------------------------------------
  // One-hot opcode decode of the latched instruction
  // ------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_opcode
      assign OPCODE[gi] = (r_ir[11:9] == 3'(gi));
    end
  endgenerate

  // ------------------------------------------------------------------
  // Current phase index
  // ------------------------------------------------------------------

  // Encode the single active CK window. Report 4'hF when no window or several
  // windows are active.
  always_comb begin
    w_curphase = 4'hF;
    if (!w_ck_multi) begin
      for (int i = 0; i < 10; i++) begin
        if (CK[i]) begin
          w_curphase = 4'(i);
        end
      end
    end
  end

  assign CURPHASE = w_curphase;

endmodule

// File: tb/tb_instruction_control.sv
// Testbench for instruction_control.
// The stimulus drives directed Sequencer phase sequences. Each expected response is
// pushed into a scoreboard queue and tagged with the cycle in which it should appear.
// A monitor on the falling clock edge pops those entries and compares them. It also
// flags any DONE pulse that no entry asked for.

module tb_instruction_control;

  localparam int CNT_W = 4;

  localparam int SIG_SEQTYPE  = 0;
  localparam int SIG_IR       = 1;
  localparam int SIG_INSTCNT  = 2;
  localparam int SIG_SEQERR   = 3;
  localparam int SIG_DONE     = 4;
  localparam int SIG_CURPHASE = 5;
  localparam int SIG_OPCODE   = 6;

  logic             SYSCLK = 1'b0;
  logic             RESET;
  logic [9:0]       CK;
  logic [9:0]       STB;
  logic [11:0]      MEMDATA;
  logic [1:0]       SEQTYPE;
  logic             DONE;
  logic [11:0]      IR;
  logic [7:0]       OPCODE;
  logic [3:0]       CURPHASE;
  logic [CNT_W-1:0] INSTCNT;
  logic             SEQERR;

  instruction_control #(.CNT_W(CNT_W)) dut (
    .SYSCLK   (SYSCLK),
    .RESET    (RESET),
    .CK       (CK),
    .STB      (STB),
    .MEMDATA  (MEMDATA),
    .SEQTYPE  (SEQTYPE),
    .DONE     (DONE),
    .IR       (IR),
    .OPCODE   (OPCODE),
    .CURPHASE (CURPHASE),
    .INSTCNT  (INSTCNT),
    .SEQERR   (SEQERR)
  );

  always #5 SYSCLK = ~SYSCLK;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  always @(posedge SYSCLK) cyc <= cyc + 1;

  function automatic int get_actual(input int sig);
    case (sig)
      SIG_SEQTYPE:  return int'(SEQTYPE);
      SIG_IR:       return int'(IR);
      SIG_INSTCNT:  return int'(INSTCNT);
      SIG_SEQERR:   return int'(SEQERR);
      SIG_DONE:     return int'(DONE);
      SIG_CURPHASE: return int'(CURPHASE);
      default:      return int'(OPCODE);
    endcase
  endfunction

  // Monitor: compare every expectation due in this cycle, and catch spurious DONE.
  exp_t mon_e;
  int   mon_act;
  bit   mon_done_exp;
  always @(negedge SYSCLK) begin
    mon_done_exp = 1'b0;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      n_total++;
      if (mon_e.cyc < cyc) begin
        $display("FAIL %s: stale entry for cycle %0d seen at cycle %0d", mon_e.name, mon_e.cyc, cyc);
      end else begin
        mon_act = get_actual(mon_e.sig);
        if (mon_e.sig == SIG_DONE && mon_e.val == 1) mon_done_exp = 1'b1;
        if (mon_act == mon_e.val) begin
          n_pass++;
          $display("cycle %0d check %s: got %0h", cyc, mon_e.name, mon_act);
        end else begin
          $display("FAIL %s: got %0h expected %0h (cycle %0d)", mon_e.name, mon_act, mon_e.val, cyc);
        end
      end
    end
    if (DONE === 1'b1 && !mon_done_exp) begin
      n_total++;
      $display("FAIL unexpected_done: got 1 expected 0 (cycle %0d)", cyc);
    end
  end

  task automatic chk(input string name, input int sig, input int val);
    exp_t e;
    e.cyc  = cyc;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step(input logic [9:0] ck, input logic [9:0] stb, input logic [11:0] mem);
    @(posedge SYSCLK);
    #1;
    CK      = ck;
    STB     = stb;
    MEMDATA = mem;
  endtask

  // One phase window: one open cycle, then the strobe cycle. It returns in the strobe cycle.
  task automatic phase(input int k, input logic [11:0] mem);
    logic [9:0] b;
    b = 10'b00_0000_0001 << k;
    step(b, 10'd0, mem);
    step(b, b, mem);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step(10'd0, 10'd0, 12'd0);
    step(10'd1, 10'd1, 12'o5410);
    chk("rst_seqtype", SIG_SEQTYPE, 0);
    chk("rst_done", SIG_DONE, 0);
    step(10'd0, 10'd0, 12'd0);
    RESET = 1'b0;
    chk("rst_ir", SIG_IR, 0);
    chk("rst_instcnt", SIG_INSTCNT, 0);
    chk("rst_seqerr", SIG_SEQERR, 0);
    chk("rst_curphase", SIG_CURPHASE, 'hF);
    chk("rst_opcode", SIG_OPCODE, 'h01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET   = 1'b1;
    CK      = 10'd0;
    STB     = 10'd0;
    MEMDATA = 12'd0;
    do_reset();

    // TAD direct: no address phases, DONE on the second execute strobe
    phase(0, 12'o1234);
    chk("tad_seqtype", SIG_SEQTYPE, 0);
    chk("tad_curphase0", SIG_CURPHASE, 0);
    phase(4, 12'd0);
    chk("tad_ir", SIG_IR, 'o1234);
    chk("tad_opcode", SIG_OPCODE, 'h02);
    chk("tad_done_p1", SIG_DONE, 0);
    chk("tad_curphase4", SIG_CURPHASE, 4);
    phase(5, 12'd0);
    chk("tad_done_p2", SIG_DONE, 1);
    step(10'd0, 10'd0, 12'd0);
    chk("tad_instcnt", SIG_INSTCNT, 1);
    chk("tad_seqerr", SIG_SEQERR, 0);
    chk("tad_curphase_none", SIG_CURPHASE, 'hF);

    // JMP I 10: autoindex sequence AUTO1, AUTO2, IND, then one execute phase
    phase(0, 12'o5410);
    chk("jmpi_seqtype", SIG_SEQTYPE, 3);
    phase(1, 12'd0);
    chk("jmpi_done_a1", SIG_DONE, 0);
    phase(2, 12'd0);
    chk("jmpi_done_a2", SIG_DONE, 0);
    phase(3, 12'd0);
    chk("jmpi_done_ind", SIG_DONE, 0);
    phase(4, 12'd0);
    chk("jmpi_done_p1", SIG_DONE, 1);
    step(10'd0, 10'd0, 12'd0);
    chk("jmpi_instcnt", SIG_INSTCNT, 2);
    chk("jmpi_seqerr", SIG_SEQERR, 0);
    chk("jmpi_ir", SIG_IR, 'o5410);
    chk("jmpi_opcode", SIG_OPCODE, 'h20);
    chk("jmpi_seqtype_ir", SIG_SEQTYPE, 3);

    // ISZ I 200: one indirect phase, three execute phases
    phase(0, 12'o2600);
    chk("iszi_seqtype", SIG_SEQTYPE, 1);
    phase(3, 12'd0);
    chk("iszi_done_ind", SIG_DONE, 0);
    phase(4, 12'd0);
    chk("iszi_done_p1", SIG_DONE, 0);
    phase(5, 12'd0);
    chk("iszi_done_p2", SIG_DONE, 0);
    phase(6, 12'd0);
    chk("iszi_done_p3", SIG_DONE, 1);
    step(10'd0, 10'd0, 12'd0);
    chk("iszi_instcnt", SIG_INSTCNT, 3);
    chk("iszi_seqerr", SIG_SEQERR, 0);

    // OPR followed by an out-of-order STB[6]: sticky error, later instructions still run
    phase(0, 12'o7200);
    chk("opr_seqtype", SIG_SEQTYPE, 0);
    phase(6, 12'd0);
    chk("opr_bad_done", SIG_DONE, 0);
    chk("opr_seqerr_before", SIG_SEQERR, 0);
    step(10'd0, 10'd0, 12'd0);
    chk("opr_seqerr_after", SIG_SEQERR, 1);
    chk("opr_instcnt", SIG_INSTCNT, 3);
    phase(0, 12'o1234);
    phase(4, 12'd0);
    phase(5, 12'd0);
    chk("recover_done", SIG_DONE, 1);
    step(10'd0, 10'd0, 12'd0);
    chk("recover_instcnt", SIG_INSTCNT, 4);
    chk("sticky_seqerr", SIG_SEQERR, 1);
    do_reset();

    // Two STB bits in one cycle
    step(10'd1, 10'b00_0000_0011, 12'o1234);
    step(10'd0, 10'd0, 12'd0);
    chk("multistb_seqerr", SIG_SEQERR, 1);
    chk("multistb_ir", SIG_IR, 'o1234);
    do_reset();

    // Two CK bits in one cycle
    step(10'b00_0000_0011, 10'd0, 12'd0);
    chk("multick_curphase", SIG_CURPHASE, 'hF);
    step(10'd0, 10'd0, 12'd0);
    chk("multick_seqerr", SIG_SEQERR, 1);
    do_reset();

    // Reset during execute phase 1 of a JMP (DONE would otherwise fire on this strobe)
    phase(0, 12'o5000);
    chk("rstmid_seqtype", SIG_SEQTYPE, 0);
    step(10'b00_0001_0000, 10'd0, 12'd0);
    step(10'b00_0001_0000, 10'b00_0001_0000, 12'd0);
    RESET = 1'b1;
    chk("rstmid_done", SIG_DONE, 0);
    step(10'd0, 10'd0, 12'd0);
    RESET = 1'b0;
    chk("rstmid_ir", SIG_IR, 0);
    chk("rstmid_seqerr", SIG_SEQERR, 0);
    // The FSM is back in IDLE, so a bare STB[4] is a protocol error.
    phase(4, 12'd0);
    chk("rstmid_stb4_done", SIG_DONE, 0);
    step(10'd0, 10'd0, 12'd0);
    chk("rstmid_idle_err", SIG_SEQERR, 1);
    chk("rstmid_instcnt", SIG_INSTCNT, 0);
    do_reset();

    // Counter wrap: fifteen JMPs bring it to all-ones, and one more wraps it to zero.
    for (int i = 0; i < 15; i++) begin
      phase(0, 12'o5000);
      phase(4, 12'd0);
      chk("wrap_jmp_done", SIG_DONE, 1);
    end
    step(10'd0, 10'd0, 12'd0);
    chk("wrap_instcnt_max", SIG_INSTCNT, 15);
    phase(0, 12'o5000);
    phase(4, 12'd0);
    chk("wrap_last_done", SIG_DONE, 1);
    step(10'd0, 10'd0, 12'd0);
    chk("wrap_instcnt_zero", SIG_INSTCNT, 0);
    chk("wrap_seqerr", SIG_SEQERR, 0);

    // Let the monitor drain. Then check that no expectation was left unconsumed.
    step(10'd0, 10'd0, 12'd0);
    step(10'd0, 10'd0, 12'd0);
    @(posedge SYSCLK);
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
